// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// A grant covers one burst of up to MAX_BURST words; stalls on fifo_full.
//
// state | meaning
// IDLE  | no owner; pick next requester from rr_ptr onward
// GRANT | grant_id owns the FIFO write port until release
module fifo_write_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                       wclk,
    input  logic                       wrst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_last,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_w_en,
    output logic [DATA_WIDTH-1:0]      fifo_data_in,
    output logic [NREQ-1:0]            grant,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       busy,
    output logic [15:0]                wr_count
);
    localparam int IDW = $clog2(NREQ);
    localparam int BCW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t          state, state_d;
    logic [NREQ-1:0] grant_d;
    logic [IDW-1:0]  grant_id_d, rr_ptr, rr_ptr_d;
    logic [BCW-1:0]  burst_cnt, burst_cnt_d;
    logic [15:0]     wr_count_d;
    logic [IDW-1:0]  pick, hi_idx, lo_idx;
    logic            hi_hit;
    logic            g_valid, g_last, transfer;

    assign busy = (state == GRANT);

    // Lowest valid index at or above rr_ptr wins, else lowest valid overall.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_hit = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = IDW'(i);
                if (IDW'(i) >= rr_ptr) begin
                    hi_idx = IDW'(i);
                    hi_hit = 1'b1;
                end
            end
        end
        pick = hi_hit ? hi_idx : lo_idx;
    end

    always_comb begin
        g_valid      = 1'b0;
        g_last       = 1'b0;
        fifo_data_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (busy && (grant_id == IDW'(i))) begin
                g_valid      = req_valid[i];
                g_last       = req_last[i];
                fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // grant is all-zero in IDLE, so ready needs no separate state qualifier.
    assign req_ready = fifo_full ? '0 : grant;
    assign transfer  = busy & g_valid & ~fifo_full;
    assign fifo_w_en = transfer;

    always_comb begin
        state_d     = state;
        grant_d     = grant;
        grant_id_d  = grant_id;
        rr_ptr_d    = rr_ptr;
        burst_cnt_d = burst_cnt;
        wr_count_d  = transfer ? wr_count + 16'd1 : wr_count;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_d     = GRANT;
                    grant_d     = NREQ'(1) << pick;
                    grant_id_d  = pick;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                if (transfer) begin
                    burst_cnt_d = burst_cnt + BCW'(1);
                end
                if (!g_valid || (transfer && (g_last || burst_cnt_d == BCW'(MAX_BURST)))) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    grant_id_d = '0;
                    rr_ptr_d   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state     <= IDLE;
            grant     <= '0;
            grant_id  <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            wr_count  <= '0;
        end else begin
            state     <= state_d;
            grant     <= grant_d;
            grant_id  <= grant_id_d;
            rr_ptr    <= rr_ptr_d;
            burst_cnt <= burst_cnt_d;
            wr_count  <= wr_count_d;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: queue-fed producers, a transaction-level
// ownership model, per-requester ordering scoreboard and directed scenarios.
module tb_fifo_write_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;

    logic              wclk = 1'b0;
    logic              wrst_n = 1'b0;
    logic [NREQ-1:0]   req_valid, req_last, req_ready, grant;
    logic [NREQ*DW-1:0] req_data;
    logic              fifo_full, fifo_w_en, busy;
    logic [DW-1:0]     fifo_data_in;
    logic [1:0]        grant_id;
    logic [15:0]       wr_count;

    fifo_write_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_w_en(fifo_w_en), .fifo_data_in(fifo_data_in), .grant(grant),
        .grant_id(grant_id), .busy(busy), .wr_count(wr_count)
    );

    always #5 wclk = ~wclk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] qd[NREQ][$];
    bit         ql[NREQ][$];
    bit         mask[NREQ];
    bit         full_r;
    int         gen_seq[NREQ];
    int         exp_seq[NREQ];

    // model: current owner (-1 = nobody), search start, words in burst, total written
    int          m_owner, m_ptr, m_words;
    logic [15:0] m_wr;

    logic [3:0]  lg_grant[$];
    logic [3:0]  lg_rdy[$];
    logic        lg_wen[$];
    logic [7:0]  lg_data[$];
    logic [15:0] lg_wc[$];
    int          n_writes;

    task automatic apply_inputs();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (qd[i].size() > 0 && !mask[i]) begin
                req_valid[i]           = 1'b1;
                req_last[i]            = ql[i][0];
                req_data[i*DW +: DW]   = qd[i][0];
            end
        end
        fifo_full = full_r;
    endtask

    task automatic push(int i, bit last);
        qd[i].push_back(8'(i * 64 + (gen_seq[i] % 64)));
        ql[i].push_back(last);
        gen_seq[i]++;
    endtask

    task automatic clear_logs();
        lg_grant.delete(); lg_rdy.delete(); lg_wen.delete();
        lg_data.delete();  lg_wc.delete();
        n_writes = 0;
    endtask

    // One clock: check DUT against model just before the edge, advance model, clock.
    task automatic cycle();
        logic [3:0] e_grant, e_rdy;
        logic       e_wen;
        logic [7:0] e_data;
        int         g, id, c;
        bit         lst;
        #1;
        if (!wrst_n) begin
            m_owner = -1; m_ptr = 0; m_words = 0; m_wr = '0;
        end
        g       = m_owner;
        e_grant = (g < 0) ? 4'b0 : 4'(1 << g);
        e_rdy   = (g >= 0 && !fifo_full) ? e_grant : 4'b0;
        e_wen   = 1'b0;
        e_data  = '0;
        if (g >= 0) begin
            e_wen  = req_valid[g] && !fifo_full;
            e_data = req_data[g*DW +: DW];
        end
        checks++;
        if (grant !== e_grant) begin
            failures++; $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, grant, e_grant);
        end
        checks++;
        if (grant_id !== 2'((g < 0) ? 0 : g)) begin
            failures++; $display("FAIL grant_id cyc=%0d got=%0d exp=%0d", cyc, grant_id, (g < 0) ? 0 : g);
        end
        checks++;
        if (busy !== (g >= 0)) begin
            failures++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, g >= 0);
        end
        checks++;
        if (req_ready !== e_rdy) begin
            failures++; $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_rdy);
        end
        checks++;
        if (fifo_w_en !== e_wen) begin
            failures++; $display("FAIL fifo_w_en cyc=%0d got=%b exp=%b", cyc, fifo_w_en, e_wen);
        end
        checks++;
        if (fifo_data_in !== e_data) begin
            failures++; $display("FAIL fifo_data_in cyc=%0d got=%h exp=%h", cyc, fifo_data_in, e_data);
        end
        checks++;
        if (wr_count !== m_wr) begin
            failures++; $display("FAIL wr_count cyc=%0d got=%0d exp=%0d", cyc, wr_count, m_wr);
        end
        if (fifo_w_en === 1'b1) begin
            n_writes++;
            id = int'(fifo_data_in[7:6]);
            checks++;
            if (fifo_data_in[5:0] !== 6'(exp_seq[id])) begin
                failures++;
                $display("FAIL order cyc=%0d req=%0d got=%0d exp=%0d", cyc, id, fifo_data_in[5:0], exp_seq[id] % 64);
            end
            exp_seq[id]++;
        end
        lg_grant.push_back(grant);
        lg_rdy.push_back(req_ready);
        lg_wen.push_back(fifo_w_en);
        lg_data.push_back(fifo_data_in);
        lg_wc.push_back(wr_count);
        if (wrst_n) begin
            if (g < 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    c = (m_ptr + k) % NREQ;
                    if (m_owner < 0 && req_valid[c]) begin
                        m_owner = c;
                        m_words = 0;
                    end
                end
            end else if (!req_valid[g]) begin
                m_owner = -1; m_ptr = (g + 1) % NREQ;
            end else if (!fifo_full) begin
                lst = req_last[g];
                m_words++;
                m_wr = m_wr + 16'd1;
                void'(qd[g].pop_front());
                void'(ql[g].pop_front());
                if (lst || m_words == MAXB) begin
                    m_owner = -1; m_ptr = (g + 1) % NREQ;
                end
            end
        end
        @(posedge wclk);
        @(negedge wclk);
        cyc++;
        apply_inputs();
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        full_r = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            qd[i].delete(); ql[i].delete();
            mask[i] = 1'b0; gen_seq[i] = 0; exp_seq[i] = 0;
        end
        apply_inputs();
        cycle();
        cycle();
        wrst_n = 1'b1;
        apply_inputs();
        clear_logs();
    endtask

    task automatic test_reset();
        wrst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) push(i, 1'b0);
        apply_inputs();
        clear_logs();
        for (int k = 0; k < 4; k++) cycle();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (lg_grant[k] !== 4'b0 || lg_wen[k] !== 1'b0 || lg_rdy[k] !== 4'b0 || lg_wc[k] !== 16'd0) begin
                failures++;
                $display("FAIL reset_hold k=%0d grant=%b wen=%b rdy=%b wc=%0d required all zero",
                         k, lg_grant[k], lg_wen[k], lg_rdy[k], lg_wc[k]);
            end
        end
    endtask

    task automatic test_single_burst();
        do_reset();
        gen_seq[0] = 16; exp_seq[0] = 16;
        push(0, 1'b0); push(0, 1'b0); push(0, 1'b1);
        apply_inputs();
        for (int k = 0; k < 6; k++) cycle();
        checks++;
        if (lg_grant[0] !== 4'b0 || lg_grant[1] !== 4'b0001) begin
            failures++; $display("FAIL single_latency got=%b,%b exp=0000,0001", lg_grant[0], lg_grant[1]);
        end
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (lg_wen[k] !== 1'b1 || lg_data[k] !== 8'(8'h10 + k - 1)) begin
                failures++; $display("FAIL single_data k=%0d wen=%b got=%h exp=%h", k, lg_wen[k], lg_data[k], 8'h10 + k - 1);
            end
        end
        checks++;
        if (lg_grant[4] !== 4'b0 || lg_wen[4] !== 1'b0) begin
            failures++; $display("FAIL single_release grant=%b wen=%b exp idle", lg_grant[4], lg_wen[4]);
        end
        checks++;
        if (lg_wc[5] !== 16'd3) begin
            failures++; $display("FAIL single_wr_count got=%0d exp=3", lg_wc[5]);
        end
        push(0, 1'b1); push(1, 1'b1);
        apply_inputs();
        clear_logs();
        for (int k = 0; k < 3; k++) cycle();
        checks++;
        if (lg_grant[1] !== 4'b0010) begin
            failures++; $display("FAIL single_next_ptr got=%b exp=0010", lg_grant[1]);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        int         r;
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 20; k++) push(i, 1'b0);
        apply_inputs();
        for (int k = 0; k < 26; k++) cycle();
        for (int c = 0; c < 25; c++) begin
            eg = 4'b0;
            if (c > 0) begin
                r = (c - 1) % 5;
                if (r != 4) eg = 4'(1 << (((c - 1) / 5) % 4));
            end
            checks++;
            if (lg_grant[c] !== eg || lg_wen[c] !== (eg != 4'b0)) begin
                failures++; $display("FAIL rr_seq c=%0d grant=%b wen=%b exp grant=%b", c, lg_grant[c], lg_wen[c], eg);
            end
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int k = 0; k < 4; k++) push(2, 1'b0);
        apply_inputs();
        for (int k = 0; k < 3; k++) cycle();
        full_r = 1'b1; apply_inputs();
        for (int k = 0; k < 3; k++) cycle();
        full_r = 1'b0; apply_inputs();
        for (int k = 0; k < 3; k++) cycle();
        for (int k = 3; k <= 5; k++) begin
            checks++;
            if (lg_wen[k] !== 1'b0 || lg_rdy[k] !== 4'b0 || lg_grant[k] !== 4'b0100) begin
                failures++; $display("FAIL stall k=%0d wen=%b rdy=%b grant=%b exp 0,0000,0100", k, lg_wen[k], lg_rdy[k], lg_grant[k]);
            end
        end
        checks++;
        if (lg_wen[6] !== 1'b1 || lg_data[6] !== 8'h82 || lg_wen[7] !== 1'b1 || lg_data[7] !== 8'h83) begin
            failures++; $display("FAIL stall_resume got=%b:%h %b:%h exp 1:82 1:83", lg_wen[6], lg_data[6], lg_wen[7], lg_data[7]);
        end
        checks++;
        if (lg_wc[8] !== 16'd4 || lg_grant[8] !== 4'b0) begin
            failures++; $display("FAIL stall_end wc=%0d grant=%b exp 4,0000", lg_wc[8], lg_grant[8]);
        end
    endtask

    task automatic test_valid_drop();
        do_reset();
        for (int k = 0; k < 3; k++) push(1, 1'b0);
        push(2, 1'b0); push(2, 1'b1);
        apply_inputs();
        for (int k = 0; k < 2; k++) cycle();
        mask[1] = 1'b1; apply_inputs();
        for (int k = 0; k < 3; k++) cycle();
        checks++;
        if (lg_grant[1] !== 4'b0010 || lg_wen[1] !== 1'b1 || lg_data[1] !== 8'h40) begin
            failures++; $display("FAIL drop_first grant=%b wen=%b data=%h exp 0010,1,40", lg_grant[1], lg_wen[1], lg_data[1]);
        end
        checks++;
        if (lg_wen[2] !== 1'b0 || lg_wen[3] !== 1'b0 || lg_grant[3] !== 4'b0) begin
            failures++; $display("FAIL drop_release wen=%b,%b grant=%b exp 0,0,0000", lg_wen[2], lg_wen[3], lg_grant[3]);
        end
        checks++;
        if (lg_grant[4] !== 4'b0100 || lg_data[4] !== 8'h80) begin
            failures++; $display("FAIL drop_next grant=%b data=%h exp 0100,80", lg_grant[4], lg_data[4]);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int k = 0; k < 4; k++) push(2, 1'b0);
        apply_inputs();
        for (int k = 0; k < 3; k++) cycle();
        wrst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0 || fifo_w_en !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL async_reset grant=%b wen=%b rdy=%b busy=%b exp zero", grant, fifo_w_en, req_ready, busy);
        end
        push(0, 1'b1);
        apply_inputs();
        cycle();
        wrst_n = 1'b1;
        apply_inputs();
        clear_logs();
        for (int k = 0; k < 3; k++) cycle();
        checks++;
        if (lg_grant[1] !== 4'b0001) begin
            failures++; $display("FAIL post_reset_ptr got=%b exp=0001", lg_grant[1]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            cycle();
            for (int i = 0; i < NREQ; i++)
                if (qd[i].size() < 4 && $urandom_range(0, 2) == 0)
                    push(i, $urandom_range(0, 3) == 0);
            full_r = ($urandom_range(0, 4) == 0);
            apply_inputs();
        end
        full_r = 1'b0;
        apply_inputs();
        cycle();
        checks++;
        if (wr_count !== 16'(n_writes)) begin
            failures++; $display("FAIL random_total got=%0d exp=%0d", wr_count, n_writes);
        end
    endtask

    initial begin
        full_r = 1'b0;
        m_owner = -1; m_ptr = 0; m_words = 0; m_wr = '0;
        for (int i = 0; i < NREQ; i++) begin
            mask[i] = 1'b0; gen_seq[i] = 0; exp_seq[i] = 0;
        end
        apply_inputs();
        @(negedge wclk);
        test_reset();
        test_single_burst();
        test_round_robin();
        test_full_stall();
        test_valid_drop();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
